// File: rtl/lcd_capture.sv
// lcd_capture: captures a 160x144, 2-bit-per-pixel LCD stream, packs four
// pixels per byte and offers each byte to a framebuffer sink through a small
// valid/ready FIFO.
// Optional feature: define LCD_CAPTURE_DROP_CNT_EN to add the drop_cnt output,
// a saturating count of entries dropped because the FIFO was full.
`timescale 1ns/1ps

module lcd_capture #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic        lcd_pixel,
    input  logic [1:0]  lcd_color,
    output logic [12:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic        frame_done,
    output logic        overflow
`ifdef LCD_CAPTURE_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic hsync_q;
    logic vsync_q;
    logic hs_rise;
    logic vs_rise;
    logic vs_fall;

    logic [7:0] x_cnt;
    logic [7:0] y_cnt;
    logic [7:0] pack_reg;

    logic        capture_pix;
    logic        push;
    logic [12:0] y_ext;
    logic [12:0] push_addr;
    logic [7:0]  push_data;

    logic [20:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             wr_en;
    logic             drop;
    logic [20:0]      head;

    assign hs_rise = lcd_hsync & ~hsync_q;
    assign vs_rise = lcd_vsync & ~vsync_q;
    assign vs_fall = ~lcd_vsync & vsync_q;

    // A pixel is only kept when it falls inside the visible 160x144 area.
    assign capture_pix = (state == CAPTURE) && lcd_pixel &&
                         (x_cnt < 8'd160) && (y_cnt < 8'd144);
    assign push        = capture_pix && (x_cnt[1:0] == 2'd3);
    assign push_data   = {pack_reg[5:0], lcd_color};

    // y*40 = y*32 + y*8, kept in 13 bits so 143*40+39 = 5759 fits.
    assign y_ext     = {5'd0, y_cnt};
    assign push_addr = (y_ext << 5) + (y_ext << 3) + {7'd0, x_cnt[7:2]};

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fb_valid   = ~fifo_empty;
    assign pop        = fb_valid & fb_ready;
    assign wr_en      = push & (~fifo_full | pop);
    assign drop       = push & fifo_full & ~pop;

    assign head    = mem[rd_ptr];
    assign fb_addr = fifo_empty ? 13'd0 : head[20:8];
    assign fb_data = fifo_empty ? 8'd0  : head[7:0];

    // Registered copies of the sync inputs for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            hsync_q <= lcd_hsync;
            vsync_q <= lcd_vsync;
        end
    end

    // Frame FSM: tracks pixel position, packs pixels and sequences the frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_FRAME;
            x_cnt      <= 8'd0;
            y_cnt      <= 8'd0;
            pack_reg   <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                WAIT_FRAME: begin
                    if (vs_fall) begin
                        x_cnt    <= 8'd0;
                        y_cnt    <= 8'd0;
                        pack_reg <= 8'd0;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (capture_pix) begin
                        pack_reg <= {pack_reg[5:0], lcd_color};
                    end
                    // A pixel coinciding with the hsync edge still belongs to
                    // the old line, so the line advance wins over x_cnt++.
                    if (hs_rise && (x_cnt != 8'd0)) begin
                        x_cnt <= 8'd0;
                        if (y_cnt < 8'd144) begin
                            y_cnt <= y_cnt + 8'd1;
                        end
                    end else if (lcd_pixel && (x_cnt < 8'd160)) begin
                        x_cnt <= x_cnt + 8'd1;
                    end
                    if (vs_rise) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= WAIT_FRAME;
                end
                default: begin
                    state <= WAIT_FRAME;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because fb_addr/fb_data mask them when empty.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    // FIFO pointers, occupancy count and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef LCD_CAPTURE_DROP_CNT_EN
    // Saturating count of entries lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'd0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_capture.sv
// Testbench for lcd_capture: table-driven pack-order vectors plus hand-written
// frame sequences, with every framebuffer write checked against a queue of
// expected {addr, data} entries.
`timescale 1ns/1ps

module tb_lcd_capture;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lcd_hsync = 1'b0;
    logic        lcd_vsync = 1'b0;
    logic        lcd_pixel = 1'b0;
    logic [1:0]  lcd_color = 2'd0;
    logic [12:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_valid;
    logic        fb_ready = 1'b1;
    logic        frame_done;
    logic        overflow;
`ifdef LCD_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    lcd_capture #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_hsync  (lcd_hsync),
        .lcd_vsync  (lcd_vsync),
        .lcd_pixel  (lcd_pixel),
        .lcd_color  (lcd_color),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_valid   (fb_valid),
        .fb_ready   (fb_ready),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef LCD_CAPTURE_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] c3;
        logic [7:0] exp_data;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[5];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int last_done_cyc = 0;
    logic [12:0] last_addr = 13'd0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Checks any handshake about to happen, then advances one clock.
    task automatic tick();
        wr_t e;
        if (fb_valid && fb_ready) begin
            checkOutput("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("fb_addr", 32'(fb_addr), 32'(e.addr));
                checkOutput("fb_data", 32'(fb_data), 32'(e.data));
            end
            wr_cnt++;
            last_addr = fb_addr;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fb_valid) last_valid_cyc = cyc;
        if (frame_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic applyStimulus(input logic hs, input logic vs, input logic px,
                                 input logic [1:0] col);
        lcd_hsync = hs;
        lcd_vsync = vs;
        lcd_pixel = px;
        lcd_color = col;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 2'd0);
        applyStimulus(0, 0, 0, 2'd0);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic start_frame();
        applyStimulus(0, 1, 0, 2'd0);
        applyStimulus(0, 0, 0, 2'd0);
    endtask

    task automatic hsync_pulse();
        applyStimulus(1, 0, 0, 2'd0);
        applyStimulus(0, 0, 0, 2'd0);
    endtask

    // Raises vsync and waits (bounded) for exactly one frame_done pulse.
    task automatic end_frame();
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            applyStimulus(0, 1, 0, 2'd0);
            n++;
        end
        checkOutput("frame_done_seen", 32'(done_cnt != d0), 1);
        applyStimulus(0, 1, 0, 2'd0);
        applyStimulus(0, 1, 0, 2'd0);
        checkOutput("frame_done_once", 32'(done_cnt - d0), 1);
    endtask

    // Drives n pixels of one shade on line y; fb_ready drops at pixel ready_off_at.
    task automatic send_line(input int y, input int n, input logic [1:0] color,
                             input int ready_off_at);
        for (int x = 0; x < n; x++) begin
            if (x == ready_off_at) fb_ready = 1'b0;
            if (x < 160 && y < 144 && (x % 4) == 3) begin
                exp_q.push_back({13'(y * 40 + x / 4), {4{color}}});
            end
            applyStimulus(0, 0, 1, color);
        end
    endtask

    initial begin
        int w0;
        int d0;

        vecs[0] = '{2'd0, 2'd1, 2'd2, 2'd3, 8'h1B};
        vecs[1] = '{2'd3, 2'd3, 2'd3, 2'd3, 8'hFF};
        vecs[2] = '{2'd3, 2'd2, 2'd1, 2'd0, 8'hE4};
        vecs[3] = '{2'd1, 2'd0, 2'd0, 2'd2, 8'h42};
        vecs[4] = '{2'd0, 2'd3, 2'd0, 2'd3, 8'h33};

        // Reset state
        do_reset();
        checkOutput("rst_fb_valid", 32'(fb_valid), 0);
        checkOutput("rst_fb_addr", 32'(fb_addr), 0);
        checkOutput("rst_fb_data", 32'(fb_data), 0);
        checkOutput("rst_frame_done", 32'(frame_done), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
`ifdef LCD_CAPTURE_DROP_CNT_EN
        checkOutput("rst_drop_cnt", 32'(drop_cnt), 0);
`endif

        // Pack order vectors, one frame each
        for (int i = 0; i < 5; i++) begin
            start_frame();
            w0 = wr_cnt;
            exp_q.push_back({13'd0, vecs[i].exp_data});
            applyStimulus(0, 0, 1, vecs[i].c0);
            applyStimulus(0, 0, 1, vecs[i].c1);
            applyStimulus(0, 0, 1, vecs[i].c2);
            applyStimulus(0, 0, 1, vecs[i].c3);
            applyStimulus(0, 0, 0, 2'd0);
            applyStimulus(0, 0, 0, 2'd0);
            checkOutput("vec_writes", 32'(wr_cnt - w0), 1);
            checkOutput("vec_addr", 32'(last_addr), 0);
            end_frame();
        end

        // Normal line and line-length corner cases
        start_frame();
        w0 = wr_cnt;
        send_line(0, 160, 2'd3, -1);
        hsync_pulse();
        checkOutput("line0_writes", 32'(wr_cnt - w0), 40);
        checkOutput("line0_last_addr", 32'(last_addr), 39);
        checkOutput("line0_overflow", 32'(overflow), 0);
        w0 = wr_cnt;
        send_line(1, 161, 2'd2, -1);
        hsync_pulse();
        checkOutput("long_line_writes", 32'(wr_cnt - w0), 40);
        checkOutput("long_line_last_addr", 32'(last_addr), 79);
        w0 = wr_cnt;
        send_line(2, 2, 2'd1, -1);
        hsync_pulse();
        checkOutput("short_line_writes", 32'(wr_cnt - w0), 0);
        w0 = wr_cnt;
        send_line(3, 4, 2'd1, -1);
        applyStimulus(0, 0, 0, 2'd0);
        applyStimulus(0, 0, 0, 2'd0);
        checkOutput("after_short_writes", 32'(wr_cnt - w0), 1);
        checkOutput("after_short_addr", 32'(last_addr), 120);
        hsync_pulse();
        hsync_pulse();
        w0 = wr_cnt;
        send_line(4, 4, 2'd2, -1);
        applyStimulus(0, 0, 0, 2'd0);
        applyStimulus(0, 0, 0, 2'd0);
        checkOutput("empty_hsync_addr", 32'(last_addr), 160);
        checkOutput("empty_hsync_writes", 32'(wr_cnt - w0), 1);
        end_frame();

        // Backpressure over a full line
        start_frame();
        fb_ready = 1'b0;
        w0 = wr_cnt;
        send_line(0, 160, 2'd1, -1);
        while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
        applyStimulus(0, 0, 0, 2'd0);
        checkOutput("bp_overflow", 32'(overflow), 1);
        checkOutput("bp_valid", 32'(fb_valid), 1);
        checkOutput("bp_head_addr", 32'(fb_addr), 0);
        checkOutput("bp_head_data", 32'(fb_data), 32'h55);
`ifdef LCD_CAPTURE_DROP_CNT_EN
        checkOutput("bp_drop_cnt", 32'(drop_cnt), 36);
`endif
        fb_ready = 1'b1;
        end_frame();
        checkOutput("bp_writes", 32'(wr_cnt - w0), 4);
        checkOutput("bp_last_addr", 32'(last_addr), 3);
        checkOutput("bp_overflow_sticky", 32'(overflow), 1);

        // Mid-frame reset after line 10
        start_frame();
        for (int y = 0; y <= 10; y++) begin
            send_line(y, 160, 2'(y % 4), -1);
            hsync_pulse();
        end
        do_reset();
        checkOutput("mrst_valid", 32'(fb_valid), 0);
        checkOutput("mrst_addr", 32'(fb_addr), 0);
        checkOutput("mrst_overflow", 32'(overflow), 0);
        w0 = wr_cnt;
        for (int x = 0; x < 8; x++) applyStimulus(0, 0, 1, 2'd3);
        start_frame();
        checkOutput("mrst_no_writes", 32'(wr_cnt - w0), 0);
        send_line(0, 4, 2'd3, -1);
        applyStimulus(0, 0, 0, 2'd0);
        applyStimulus(0, 0, 0, 2'd0);
        checkOutput("mrst_first_writes", 32'(wr_cnt - w0), 1);
        checkOutput("mrst_first_addr", 32'(last_addr), 0);
        end_frame();

        // Full frame with a backed-up FIFO at the end
        start_frame();
        w0 = wr_cnt;
        d0 = done_cnt;
        for (int y = 0; y < 144; y++) begin
            send_line(y, 160, 2'(y % 4), (y == 143) ? 148 : -1);
            hsync_pulse();
        end
        applyStimulus(0, 1, 0, 2'd0);
        applyStimulus(0, 1, 0, 2'd0);
        applyStimulus(0, 1, 0, 2'd0);
        checkOutput("ff_held_valid", 32'(fb_valid), 1);
        checkOutput("ff_no_early_done", 32'(done_cnt - d0), 0);
        fb_ready = 1'b1;
        end_frame();
        checkOutput("ff_writes", 32'(wr_cnt - w0), 5760);
        checkOutput("ff_last_addr", 32'(last_addr), 5759);
        checkOutput("ff_done_timing", 32'(last_done_cyc - last_valid_cyc), 2);
        checkOutput("ff_overflow", 32'(overflow), 0);

        checkOutput("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
